// File: rtl/axi_dma_read_burst.sv
// AXI4 read master for the DMA read path: splits one transfer into INCR bursts that never
// cross a 4 KB page and only launch when the downstream FIFO can absorb the whole burst.
module axi_dma_read_burst #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned FIFO_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_addr,
  input  logic [LEN_WIDTH-1:0]      xfer_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [DATA_WIDTH-1:0]     fifo_data,
  output logic                      fifo_wr_en,
  input  logic [FIFO_CNT_WIDTH-1:0] fifo_space
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned Shift = $clog2(Bytes);

  typedef enum logic [2:0] {StIdle, StCalc, StAddr, StData, StFin} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic [8:0]              r_burst;
  logic [8:0]              r_beat_cnt;
  logic [7:0]              r_arlen;
  logic                    r_arvalid;
  logic                    r_error;
  logic                    r_fifo_wr_en;
  logic [DATA_WIDTH-1:0]   r_fifo_data;

  logic [31:0] w_room;
  logic [31:0] w_rem32;
  logic [31:0] w_cap;
  logic [8:0]  w_burst;
  logic        w_space_ok;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_beat_err;

  // Beats left before the next 4 KB page boundary.
  assign w_room      = (32'd4096 - {20'd0, r_addr[11:0]}) >> Shift;
  assign w_rem32     = 32'(r_remaining);
  assign w_cap       = (w_rem32 < MAX_BURST) ? w_rem32 : MAX_BURST;
  assign w_burst     = 9'((w_cap < w_room) ? w_cap : w_room);
  // One extra entry covers the registered FIFO write whose space update is still pending.
  assign w_space_ok  = 32'(fifo_space) >= (32'(r_burst) + 32'd1);
  assign w_beat      = (r_state == StData) && rvalid;
  assign w_last_beat = (r_beat_cnt == (r_burst - 9'd1));
  assign w_beat_err  = (rresp != 2'b00) || (rlast != w_last_beat);

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (start) w_state_next = StCalc;
      StCalc: w_state_next = (r_remaining == '0) ? StFin : StAddr;
      StAddr: if (r_arvalid && arready) w_state_next = StData;
      StData: begin
        if (w_beat && w_last_beat) w_state_next = (r_error || w_beat_err) ? StFin : StCalc;
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
      r_arlen      <= '0;
      r_arvalid    <= 1'b0;
      r_error      <= 1'b0;
      r_fifo_wr_en <= 1'b0;
      r_fifo_data  <= '0;
    end else begin
      r_fifo_wr_en <= w_beat;
      if (w_beat) r_fifo_data <= rdata;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_addr      <= src_addr & ~ADDR_WIDTH'(Bytes - 1);
            r_remaining <= xfer_beats;
            r_error     <= 1'b0;
          end
        end
        StCalc: begin
          if (r_remaining != '0) begin
            r_burst    <= w_burst;
            r_arlen    <= 8'(w_burst - 9'd1);
            r_beat_cnt <= '0;
          end
        end
        StAddr: begin
          if (r_arvalid) begin
            if (arready) r_arvalid <= 1'b0;
          end else if (w_space_ok) begin
            r_arvalid <= 1'b1;
          end
        end
        StData: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_beat_err) r_error <= 1'b1;
            // The local beat count, not rlast, decides where the burst ends.
            if (w_last_beat) begin
              r_addr      <= r_addr + (ADDR_WIDTH'(r_burst) << Shift);
              r_remaining <= r_remaining - LEN_WIDTH'(r_burst);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != StIdle);
  assign done       = (r_state == StFin);
  assign error      = r_error;
  assign araddr     = r_addr;
  assign arlen      = r_arlen;
  assign arsize     = 3'(Shift);
  assign arburst    = 2'b01;
  assign arvalid    = r_arvalid;
  assign rready     = (r_state == StData);
  assign fifo_data  = r_fifo_data;
  assign fifo_wr_en = r_fifo_wr_en;

endmodule

// File: tb/tb_axi_dma_read_burst.sv
// Randomised bench for axi_dma_read_burst: an AXI slave, a draining FIFO and a burst-list
// reference model that predicts every AR request, every FIFO word and the final error flag.
module tb_axi_dma_read_burst;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr;
  logic [15:0] xfer_beats;
  logic        busy, done, error;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] fifo_data;
  logic        fifo_wr_en;
  logic [7:0]  fifo_space;

  always #5 clk = ~clk;

  axi_dma_read_burst #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16), .LEN_WIDTH(16), .FIFO_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .xfer_beats(xfer_beats),
    .busy(busy), .done(done), .error(error), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en), .fifo_space(fifo_space)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  ar_t         exp_ar[$];
  ar_t         obs_ar[$];
  ar_t         slv_q[$];
  logic [31:0] exp_data[$];
  bit          exp_err = 1'b0;
  logic [31:0] salt = 32'h0;
  int          err_beat = -1;
  int          err_type = 0;
  bit          ar_rand = 1'b0, r_rand = 1'b0, ar_force_low = 1'b0;
  bit          fifo_manual = 1'b0;
  logic [7:0]  manual_space = 8'd0;
  int          depth = 255;
  int          occ = 0;
  bit          overflow = 1'b0;
  int          wr_count = 0;

  assign fifo_space = fifo_manual ? manual_space : 8'(depth - occ);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: actual 0x%0h required none", name, act);
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  // Reference: walk the transfer in page-limited, MAX_BURST-limited chunks.
  task automatic build_expect(input logic [31:0] a, input int beats);
    logic [31:0] cur;
    int rem, pos, room, b;
    cur = a & ~32'd3;
    rem = beats;
    pos = 0;
    exp_ar.delete();
    exp_data.delete();
    exp_err = 1'b0;
    while (rem > 0) begin
      room = (4096 - int'(cur[11:0])) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_ar.push_back(ar_t'{cur, 8'(b - 1)});
      for (int i = 0; i < b; i++) exp_data.push_back(beat_data(cur + 32'(4 * i)));
      if (err_beat >= pos && err_beat < pos + b) begin
        exp_err = 1'b1;
        break;
      end
      pos += b;
      cur += 32'(4 * b);
      rem -= b;
    end
  endtask

  // AXI read slave.
  initial begin
    int rb, gbeat;
    bit ar_hs, r_hs, flush, st;
    logic [31:0] sa;
    logic [7:0] sl;
    rb = 0;
    gbeat = 0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      flush = reset;
      st    = start && !busy;
      sa    = araddr;
      sl    = arlen;
      @(posedge clk); #1;
      if (flush) begin
        slv_q.delete();
        rb = 0;
        gbeat = 0;
      end else begin
        if (st) gbeat = 0;
        if (ar_hs) slv_q.push_back(ar_t'{sa, sl});
        if (r_hs) begin
          rb++;
          gbeat++;
          if (rb == int'(slv_q[0].len) + 1) begin
            void'(slv_q.pop_front());
            rb = 0;
          end
        end
      end
      arready = ar_force_low ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (!(rvalid && !r_hs && !flush)) begin
        if (slv_q.size() > 0 && (!r_rand || $urandom_range(0, 2) != 0)) begin
          rvalid = 1'b1;
          rdata  = beat_data(slv_q[0].addr + 32'(4 * rb));
          rlast  = (rb == int'(slv_q[0].len));
          rresp  = 2'b00;
          if (gbeat == err_beat) begin
            if (err_type == 0) rresp = 2'b10;
            else rlast = ~rlast;
          end
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
      end
    end
  end

  // Downstream FIFO: occupancy reflects a write one cycle later, drains at random.
  initial begin
    bit wr;
    forever begin
      @(negedge clk);
      wr = fifo_wr_en;
      @(posedge clk); #1;
      if (wr) occ++;
      if (!fifo_manual && occ > depth) overflow = 1'b1;
      if (occ > 0 && $urandom_range(0, 3) == 0) occ--;
    end
  end

  // Per-cycle compare against the reference queues.
  initial begin
    logic p_arvalid, p_arready, p_rhs, p_reset;
    logic [31:0] p_araddr, d;
    logic [7:0] p_arlen, p_space;
    ar_t e;
    p_arvalid = 1'b0; p_arready = 1'b0; p_rhs = 1'b0; p_reset = 1'b1;
    p_araddr = '0; p_arlen = '0; p_space = '0;
    forever begin
      @(negedge clk);
      if (!reset && !p_reset) begin
        if (p_arvalid && !p_arready) begin
          chk("ar_hold_valid", arvalid, 1'b1);
          chk("ar_hold_addr", araddr, p_araddr);
          chk("ar_hold_len", arlen, p_arlen);
        end
        if (arvalid && !p_arvalid)
          chk("ar_space", (32'(p_space) >= 32'(arlen) + 32'd2), 1'b1);
        chk("wr_latency", fifo_wr_en, p_rhs);
        if (arvalid && arready) begin
          obs_ar.push_back(ar_t'{araddr, arlen});
          if (exp_ar.size() == 0) fail("ar_unexpected", araddr);
          else begin
            e = exp_ar.pop_front();
            chk("ar_addr", araddr, e.addr);
            chk("ar_len", arlen, e.len);
          end
        end
        if (fifo_wr_en) begin
          wr_count++;
          if (exp_data.size() == 0) fail("fifo_unexpected", fifo_data);
          else begin
            d = exp_data.pop_front();
            chk("fifo_data", fifo_data, d);
          end
        end
        if (done) begin
          chk("done_error", error, exp_err);
          chk("done_ar_left", exp_ar.size(), 0);
          chk("done_data_left", exp_data.size(), 0);
          chk("done_busy", busy, 1'b1);
          chk("fifo_overflow", overflow, 1'b0);
        end
      end
      p_arvalid = arvalid; p_arready = arready; p_araddr = araddr; p_arlen = arlen;
      p_rhs = rvalid && rready; p_space = fifo_space; p_reset = reset;
    end
  end

  task automatic pulse_start(input logic [31:0] a, input int beats);
    @(posedge clk); #1;
    start = 1'b1; src_addr = a; xfer_beats = 16'(beats);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    if (!seen) fail("done_timeout", cycles);
    else begin
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
    end
  endtask

  task automatic wait_fifo_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (occ == 0) ok = 1'b1;
    end
    if (!ok) fail("fifo_drain_timeout", occ);
  endtask

  task automatic run_xfer(input logic [31:0] a, input int beats, input bit garbage,
                          output int wrs, output int cycles);
    int w0;
    build_expect(a, beats);
    obs_ar.delete();
    w0 = wr_count;
    pulse_start(a, beats);
    if (garbage) begin
      @(posedge clk); #1;
      start = 1'b1; src_addr = $urandom; xfer_beats = 16'($urandom_range(1, 99));
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(4000, cycles);
    wrs = wr_count - w0;
  endtask

  initial begin
    int wrs, cyc;
    bit seen;
    reset = 1'b1; start = 1'b0; src_addr = '0; xfer_beats = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);        chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);      chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_araddr", araddr, 32'h0);   chk("rst_arlen", arlen, 8'h0);
    chk("rst_fifo_data", fifo_data, 32'h0);
    chk("arsize", arsize, 3'd2);        chk("arburst", arburst, 2'b01);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three bursts out of a 40-beat transfer.
    salt = 32'h1234_0000;
    run_xfer(32'h1000, 40, 1'b0, wrs, cyc);
    chk("t1_nbursts", obs_ar.size(), 3);
    if (obs_ar.size() == 3) begin
      chk("t1_b0_addr", obs_ar[0].addr, 32'h1000); chk("t1_b0_len", obs_ar[0].len, 8'd15);
      chk("t1_b1_addr", obs_ar[1].addr, 32'h1040); chk("t1_b1_len", obs_ar[1].len, 8'd15);
      chk("t1_b2_addr", obs_ar[2].addr, 32'h1080); chk("t1_b2_len", obs_ar[2].len, 8'd7);
    end
    chk("t1_writes", wrs, 40);
    chk("t1_error", error, 1'b0);
    wait_fifo_empty();

    // 4 KB page split.
    run_xfer(32'h0FF0, 8, 1'b0, wrs, cyc);
    chk("t2_nbursts", obs_ar.size(), 2);
    if (obs_ar.size() == 2) begin
      chk("t2_b0_addr", obs_ar[0].addr, 32'h0FF0); chk("t2_b0_len", obs_ar[0].len, 8'd3);
      chk("t2_b1_addr", obs_ar[1].addr, 32'h1000); chk("t2_b1_len", obs_ar[1].len, 8'd3);
    end
    wait_fifo_empty();

    // FIFO space gating.
    @(negedge clk);
    fifo_manual = 1'b1; manual_space = 8'd10;
    build_expect(32'h0, 16);
    pulse_start(32'h0, 16);
    repeat (10) begin
      @(negedge clk);
      chk("t3_ar_blocked", arvalid, 1'b0);
    end
    @(posedge clk); #1;
    manual_space = 8'd17;
    @(negedge clk);
    chk("t3_ar_not_yet", arvalid, 1'b0);
    @(negedge clk);
    chk("t3_ar_valid", arvalid, 1'b1);
    chk("t3_ar_len", arlen, 8'd15);
    wait_done(1000, cyc);
    @(negedge clk);
    fifo_manual = 1'b0;
    wait_fifo_empty();

    // SLVERR on the third beat of the first burst.
    err_beat = 2; err_type = 0;
    run_xfer(32'h2000, 40, 1'b0, wrs, cyc);
    chk("t4_nbursts", obs_ar.size(), 1);
    chk("t4_writes", wrs, 16);
    chk("t4_error", error, 1'b1);
    err_beat = -1;
    wait_fifo_empty();
    build_expect(32'h3000, 4);
    pulse_start(32'h3000, 4);
    @(negedge clk);
    chk("t4_error_cleared", error, 1'b0);
    wait_done(1000, cyc);
    wait_fifo_empty();

    // AR stall stability.
    @(negedge clk);
    ar_force_low = 1'b1;
    build_expect(32'h4000, 8);
    pulse_start(32'h4000, 8);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (arvalid) seen = 1'b1;
    end
    if (!seen) fail("t5_arvalid_timeout", 0);
    repeat (5) begin
      @(negedge clk);
      chk("t5_stall_valid", arvalid, 1'b1);
      chk("t5_stall_addr", araddr, 32'h4000);
      chk("t5_stall_len", arlen, 8'd7);
    end
    ar_force_low = 1'b0;
    wait_done(1000, cyc);
    wait_fifo_empty();

    // Zero-length transfer.
    run_xfer(32'h5000, 0, 1'b0, wrs, cyc);
    chk("t5_zero_latency_ok", (cyc <= 3), 1'b1);
    chk("t5_zero_no_ar", obs_ar.size(), 0);

    // Reset in the middle of a data phase.
    r_rand = 1'b1;
    build_expect(32'h6000, 40);
    pulse_start(32'h6000, 40);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rready && fifo_wr_en) seen = 1'b1;
    end
    if (!seen) fail("t6_data_timeout", 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_no_done_in_reset", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_arvalid", arvalid, 1'b0); chk("t6_rready", rready, 1'b0);
    chk("t6_busy", busy, 1'b0);       chk("t6_done", done, 1'b0);
    exp_ar.delete();
    exp_data.delete();
    wait_fifo_empty();
    run_xfer(32'h6000, 40, 1'b0, wrs, cyc);
    chk("t6_restart_writes", wrs, 40);
    chk("t6_restart_error", error, 1'b0);

    // Randomised transfers.
    for (int n = 0; n < 30; n++) begin
      int beats;
      logic [31:0] a;
      wait_fifo_empty();
      @(negedge clk);
      case ($urandom_range(0, 2))
        0: depth = 20;
        1: depth = 40;
        default: depth = 255;
      endcase
      ar_rand = 1'($urandom_range(0, 1));
      r_rand  = 1'($urandom_range(0, 1));
      salt    = $urandom;
      beats   = $urandom_range(0, 70);
      a       = $urandom & 32'hFFFF_0FFF;
      if ($urandom_range(0, 1) == 1) a = {a[31:12], 12'hF00} | ($urandom & 32'hFF);
      err_type = $urandom_range(0, 1);
      err_beat = (beats > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, beats - 1) : -1;
      run_xfer(a, beats, (beats >= 4) && ($urandom_range(0, 2) == 0), wrs, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_dma_read_burst.md
Name: axi_dma_read_burst

Overview:
Parametrised AXI4 read master for the DMA read path. It converts one software-programmed transfer (start address, beat count) into a sequence of INCR bursts of up to MAX_BURST beats each, and never lets a burst cross a 4 KB boundary. Read data is pushed into the downstream DMA FIFO. A burst is issued only when the FIFO has room for all of its beats. Errors (RRESP, RLAST mismatch) are captured and reported with completion status.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI/FIFO data width; power of two, 8..1024
MAX_BURST, 16, maximum beats per burst, 1..256
LEN_WIDTH, 16, width of the transfer beat-count input
FIFO_CNT_WIDTH, 8, width of the FIFO free-space input

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; launches a transfer when idle
src_addr  in  ADDR_WIDTH  transfer start byte address; sampled on accepted start
xfer_beats  in  LEN_WIDTH  transfer length in beats; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
error  out  1  sticky error status of the last transfer
araddr  out  ADDR_WIDTH  AXI AR address
arlen  out  8  AXI AR burst length minus one
arsize  out  3  constant log2(DATA_WIDTH/8)
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  DATA_WIDTH  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
fifo_data  out  DATA_WIDTH  FIFO write data
fifo_wr_en  out  1  FIFO write strobe
fifo_space  in  FIFO_CNT_WIDTH  FIFO free entries, updated one cycle after each write

Behaviour:
- Reset (synchronous, active-high) values: state IDLE; busy, done, error, arvalid, rready and fifo_wr_en are 0; araddr, arlen and fifo_data are 0. A reset during a transfer aborts it at the next edge. No drain occurs and no done pulse is issued.
- States:
  - IDLE: an accepted start enters CALC. A start in any other state is ignored.
  - CALC: computes the next burst and then goes to ADDR. If remaining is 0, it goes to FIN instead.
  - ADDR: drives the AR channel.
  - DATA: accepts the burst's read beats.
  - FIN: pulses done for one cycle and returns to IDLE.
- Address and length capture:
  - On an accepted start, the low log2(DATA_WIDTH/8) bits of src_addr are forced to 0 and the remaining beat count is loaded from xfer_beats.
  - error is cleared on an accepted start.
  - busy goes to 1 on the edge that accepts start and goes to 0 on the edge that leaves FIN.
- Burst size: burst_beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_WIDTH/8)). arlen = burst_beats - 1.
- ADDR state:
  - arvalid is asserted only while fifo_space >= burst_beats + 1. The extra entry covers the registered write still in flight.
  - Once asserted, arvalid, araddr and arlen hold stable until arready. arvalid is never withdrawn before the handshake.
  - On the handshake, the state goes to DATA.
- DATA state:
  - rready = 1 for the whole state.
  - Each rvalid&&rready beat registers rdata into fifo_data and pulses fifo_wr_en on the following cycle. Latency is 1 cycle; back-to-back beats give back-to-back writes.
  - The internal beat counter is authoritative. The burst ends on the burst_beats-th beat regardless of rlast.
  - On the final beat: addr += burst_beats*(DATA_WIDTH/8) and remaining -= burst_beats. rready drops at the next edge and the state goes to CALC.
  - If error is set, the state goes to FIN instead.
- Error capture: error is set if any beat has rresp != 2'b00, if rlast = 1 on a non-final beat, or if rlast = 0 on the final beat.
  - The current burst always drains fully.
  - No further bursts are issued after an error.
  - error holds until the next accepted start.
- Zero-length transfer (xfer_beats = 0): IDLE -> CALC -> FIN with done pulsed, and no AXI traffic.
- Address wrap past 2^ADDR_WIDTH is a software error. The address wraps modulo 2^ADDR_WIDTH.

Test Plan:
- src_addr=0x1000, xfer_beats=40, MAX_BURST=16, arready/rvalid always 1, fifo_space=255 -> three bursts at 0x1000/0x1040/0x1080 with arlen 15/15/7. 40 fifo_wr_en pulses carry data in order. done pulses once and error=0.
- src_addr=0x0FF0, xfer_beats=8 (32-bit data) -> two bursts: 0x0FF0 with arlen=3, then 0x1000 with arlen=3. No burst crosses 4 KB.
- fifo_space=10, xfer_beats=16 -> arvalid stays 0. Raise fifo_space to 17 -> arvalid asserts on the next cycle with arlen=15.
- rresp=2'b10 on beat 3 of a 16-beat first burst of a 40-beat transfer -> all 16 beats accepted, no second AR, done with error=1. The next start clears error.
- arready held 0 for 5 cycles -> araddr, arlen and arvalid stable throughout. xfer_beats=0 -> done within 3 cycles, arvalid never asserted.
- reset asserted mid-DATA -> next edge gives arvalid=rready=busy=0 and no done. A following start completes normally.
